// File: rtl/prbs_checker_if.sv
// prbs_checker_if: serial receive stream, tap mask and error-reporting signals of the PRBS checker.
interface prbs_checker_if #(
    parameter int LENGTH    = 16,
    parameter int ERR_WIDTH = 16
);
    logic [LENGTH-1:0]    taps;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 clear_errors;
    logic                 locked;
    logic                 bit_err;
    logic [ERR_WIDTH-1:0] err_count;

    modport master (
        output taps, bit_in, bit_valid, clear_errors,
        input  locked, bit_err, err_count
    );

    modport slave (
        input  taps, bit_in, bit_valid, clear_errors,
        output locked, bit_err, err_count
    );
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising Fibonacci PRBS checker with lock detection and saturating error count.
module prbs_checker #(
    parameter int LENGTH      = 16,
    parameter int LOCK_COUNT  = 32,
    parameter int BLOCK_LEN   = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int ERR_WIDTH   = 16
) (
    input logic             clk,
    input logic             rst,
    prbs_checker_if.slave   bus
);
    localparam int FW = $clog2(LENGTH + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(BLOCK_LEN + 1);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t               state, state_n;
    logic [LENGTH-1:0]    r, r_n;
    logic [FW-1:0]        fill, fill_n;
    logic [MW-1:0]        match, match_n;
    logic [BW-1:0]        blk_bits, blk_bits_n;
    logic [EW-1:0]        blk_errs, blk_errs_n;
    logic [ERR_WIDTH-1:0] cnt, cnt_n;
    logic                 bit_err, bit_err_n;
    logic                 p, full, hit, err, blk_full, blk_fail;

    always_comb begin
        p          = ^(bus.taps & r);
        full       = fill == FW'(LENGTH);
        hit        = full && bus.bit_in == p && r != '0;
        err        = bus.bit_in != p;
        blk_full   = blk_bits + BW'(1) == BW'(BLOCK_LEN);
        blk_fail   = blk_errs + EW'(1) == EW'(UNLOCK_ERRS);
        state_n    = state;
        r_n        = r;
        fill_n     = fill;
        match_n    = match;
        blk_bits_n = blk_bits;
        blk_errs_n = blk_errs;
        bit_err_n  = 1'b0;
        if (bus.bit_valid) begin
            if (state == SEARCH) begin
                r_n     = {bus.bit_in, r[LENGTH-1:1]};
                fill_n  = full ? fill : fill + FW'(1);
                match_n = hit ? match + MW'(1) : '0;
                if (hit && match + MW'(1) == MW'(LOCK_COUNT)) begin
                    state_n    = LOCKED;
                    match_n    = '0;
                    blk_bits_n = '0;
                    blk_errs_n = '0;
                end
            end else begin
                // Free-run on the prediction so received errors never corrupt the reference.
                r_n        = {p, r[LENGTH-1:1]};
                bit_err_n  = err;
                blk_bits_n = blk_full ? '0 : blk_bits + BW'(1);
                blk_errs_n = blk_full ? '0 : blk_errs + EW'(err);
                if (err && blk_fail) begin
                    state_n    = SEARCH;
                    fill_n     = '0;
                    match_n    = '0;
                    blk_bits_n = '0;
                    blk_errs_n = '0;
                end
            end
        end
        cnt_n = bus.clear_errors ? '0 : (bit_err_n && cnt != '1) ? cnt + ERR_WIDTH'(1) : cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEARCH;
            r        <= '0;
            fill     <= '0;
            match    <= '0;
            blk_bits <= '0;
            blk_errs <= '0;
            cnt      <= '0;
            bit_err  <= 1'b0;
        end else begin
            state    <= state_n;
            r        <= r_n;
            fill     <= fill_n;
            match    <= match_n;
            blk_bits <= blk_bits_n;
            blk_errs <= blk_errs_n;
            cnt      <= cnt_n;
            bit_err  <= bit_err_n;
        end
    end

    assign bus.locked    = state == LOCKED;
    assign bus.bit_err   = bit_err;
    assign bus.err_count = cnt;
endmodule
